dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_access_check.sv | 25 ++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings for RISC-V loads/stores and the port-1 lock
// state type shared by the data-memory arbiter and its access checker.
package dmem_pkg;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Width code presented to the memory wrapper when no port is granted.
    localparam logic [2:0] F3_IDLE = F3_SW;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED1  = 1'b1
    } lock_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, response and memory-wrapper signals of the
// data-memory arbiter. master = requesters and wrapper, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [2:0]        p0_funct3;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [2:0]        p1_funct3;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_lock;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_we;
    logic [2:0]        mem_store;
    logic [2:0]        mem_load;
    logic [ADDR_W-1:0] mem_WA;
    logic [ADDR_W-1:0] mem_RA;
    logic [DATA_W-1:0] mem_WD;
    logic [DATA_W-1:0] mem_RD;

    modport master (
        output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_lock,
        output mem_RD,
        input  p0_gnt, p0_rvalid, p0_err, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_err, p1_rdata,
        input  mem_we, mem_store, mem_load, mem_WA, mem_RA, mem_WD
    );

    modport slave (
        input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_lock,
        input  mem_RD,
        output p0_gnt, p0_rvalid, p0_err, p0_rdata,
        output p1_gnt, p1_rvalid, p1_err, p1_rdata,
        output mem_we, mem_store, mem_load, mem_WA, mem_RA, mem_WD
    );

endinterface

// File: rtl/dmem_access_check.sv
// dmem_access_check: decodes funct3, the low address bits and the direction
// into a legal-access flag (known width, loads-only unsigned forms, natural alignment).
module dmem_access_check
    import dmem_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    input  logic       we_i,
    output logic       legal_o
);

    // Legality decode per funct3 encoding.
    always_comb begin
        legal_o = 1'b0;
        case (funct3_i)
            F3_LB:   legal_o = 1'b1;
            F3_LH:   legal_o = (addr_lo_i[0] == 1'b0);
            F3_LW:   legal_o = (addr_lo_i == 2'b00);
            F3_LBU:  legal_o = !we_i;
            F3_LHU:  legal_o = !we_i && (addr_lo_i[0] == 1'b0);
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with port-1 lock and a one-cycle
// registered response. Define DMEM_ARB_RR_EN for round-robin conflict resolution.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    lock_state_e       state_q;
    lock_state_e       state_d;
    logic              p0_legal_s;
    logic              p1_legal_s;
    logic              p0_gnt_s;
    logic              p1_gnt_s;
    logic              p1_wins_s;
    logic              we_s;
    logic [2:0]        funct3_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;

    logic              p0_rvalid_q;
    logic              p0_err_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic              p1_rvalid_q;
    logic              p1_err_q;
    logic [DATA_W-1:0] p1_rdata_q;

`ifdef DMEM_ARB_RR_EN
    // prio_q = 1 means port 1 wins the next conflict.
    logic prio_q;
    logic prio_d;
    assign p1_wins_s = prio_q;
    assign prio_d    = p0_gnt_s ? 1'b1 : (p1_gnt_s ? 1'b0 : prio_q);
`else
    assign p1_wins_s = 1'b0;
`endif

    dmem_access_check u_chk_p0 (
        .funct3_i  (bus.p0_funct3),
        .addr_lo_i (bus.p0_addr[1:0]),
        .we_i      (bus.p0_we),
        .legal_o   (p0_legal_s)
    );

    dmem_access_check u_chk_p1 (
        .funct3_i  (bus.p1_funct3),
        .addr_lo_i (bus.p1_addr[1:0]),
        .we_i      (bus.p1_we),
        .legal_o   (p1_legal_s)
    );

    // Grant selection; a held lock only blocks port 0 while port 1 keeps requesting.
    always_comb begin
        p0_gnt_s = 1'b0;
        p1_gnt_s = 1'b0;
        if (!rst_n) begin
            p0_gnt_s = 1'b0;
            p1_gnt_s = 1'b0;
        end else if ((state_q == LOCKED1) && bus.p1_req) begin
            p1_gnt_s = 1'b1;
        end else if (bus.p0_req && bus.p1_req) begin
            p1_gnt_s = p1_wins_s;
            p0_gnt_s = !p1_wins_s;
        end else begin
            p0_gnt_s = bus.p0_req;
            p1_gnt_s = bus.p1_req;
        end
    end

    assign state_d = (p1_gnt_s && bus.p1_lock) ? LOCKED1 : UNLOCKED;

    // Memory-side mux; illegal accesses never write.
    always_comb begin
        we_s     = 1'b0;
        funct3_s = F3_IDLE;
        addr_s   = '0;
        wdata_s  = '0;
        if (p0_gnt_s) begin
            we_s     = bus.p0_we && p0_legal_s;
            funct3_s = bus.p0_funct3;
            addr_s   = bus.p0_addr;
            wdata_s  = bus.p0_wdata;
        end else if (p1_gnt_s) begin
            we_s     = bus.p1_we && p1_legal_s;
            funct3_s = bus.p1_funct3;
            addr_s   = bus.p1_addr;
            wdata_s  = bus.p1_wdata;
        end else begin
            we_s     = 1'b0;
            funct3_s = F3_IDLE;
        end
    end

    // Lock FSM, arbitration pointer and registered per-port responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            p0_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rvalid_q <= 1'b0;
            p1_err_q    <= 1'b0;
            p1_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            p0_rvalid_q <= p0_gnt_s;
            p0_err_q    <= p0_gnt_s && !p0_legal_s;
            p0_rdata_q  <= (p0_gnt_s && p0_legal_s && !bus.p0_we) ? bus.mem_RD : '0;
            p1_rvalid_q <= p1_gnt_s;
            p1_err_q    <= p1_gnt_s && !p1_legal_s;
            p1_rdata_q  <= (p1_gnt_s && p1_legal_s && !bus.p1_we) ? bus.mem_RD : '0;
`ifdef DMEM_ARB_RR_EN
            prio_q      <= prio_d;
`endif
        end
    end

    assign bus.p0_gnt    = p0_gnt_s;
    assign bus.p1_gnt    = p1_gnt_s;
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p0_err    = p0_err_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p1_err    = p1_err_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.mem_we    = we_s;
    assign bus.mem_store = funct3_s;
    assign bus.mem_load  = funct3_s;
    assign bus.mem_WA    = addr_s;
    assign bus.mem_RA    = addr_s;
    assign bus.mem_WD    = wdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus against a byte-array memory
// model; expectations come from the arbitration and legality rules.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory wrapper stand-in: 256 bytes, extension applied per mem_load.
    logic [7:0] wmem [256];
    logic [7:0] rb0, rb1, rb2, rb3;

    always_comb begin
        rb0 = wmem[bus.mem_RA[7:0]];
        rb1 = wmem[bus.mem_RA[7:0] + 8'd1];
        rb2 = wmem[bus.mem_RA[7:0] + 8'd2];
        rb3 = wmem[bus.mem_RA[7:0] + 8'd3];
        case (bus.mem_load)
            3'b000:  bus.mem_RD = {{24{rb0[7]}}, rb0};
            3'b001:  bus.mem_RD = {{16{rb1[7]}}, rb1, rb0};
            3'b010:  bus.mem_RD = {rb3, rb2, rb1, rb0};
            3'b100:  bus.mem_RD = {24'h000000, rb0};
            3'b101:  bus.mem_RD = {16'h0000, rb1, rb0};
            default: bus.mem_RD = 32'h00000000;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            case (bus.mem_store)
                3'b000: wmem[bus.mem_WA[7:0]] <= bus.mem_WD[7:0];
                3'b001: begin
                    wmem[bus.mem_WA[7:0]]         <= bus.mem_WD[7:0];
                    wmem[bus.mem_WA[7:0] + 8'd1]  <= bus.mem_WD[15:8];
                end
                3'b010: begin
                    wmem[bus.mem_WA[7:0]]         <= bus.mem_WD[7:0];
                    wmem[bus.mem_WA[7:0] + 8'd1]  <= bus.mem_WD[15:8];
                    wmem[bus.mem_WA[7:0] + 8'd2]  <= bus.mem_WD[23:16];
                    wmem[bus.mem_WA[7:0] + 8'd3]  <= bus.mem_WD[31:24];
                end
                default: ;
            endcase
        end
    end

    // Reference state: byte memory, lock ownership, most recently granted port.
    logic [7:0] ref_mem [256];
    bit         lock_m;
    bit         last_m;
    bit         obs_g0;
    bit         obs_g1;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return (addr % ref_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        int     sz;
        longint v;
        sz = ref_size(f3);
        v  = 0;
        for (int i = 0; i < sz; i++)
            v = v + (longint'(ref_mem[(addr + i) & 255]) << (8 * i));
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
        for (int i = 0; i < ref_size(f3); i++)
            ref_mem[(addr + i) & 255] = data[8*i +: 8];
    endtask

    task automatic set_p0(input bit req, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.p0_req = req; bus.p0_we = we; bus.p0_funct3 = f3;
        bus.p0_addr = addr; bus.p0_wdata = wdata;
    endtask

    task automatic set_p1(input bit req, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit lock);
        bus.p1_req = req; bus.p1_we = we; bus.p1_funct3 = f3;
        bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_lock = lock;
    endtask

    // One clock of traffic: check grant and memory side, then the response.
    task automatic step(input string tag);
        bit          g0, g1, win1, wev, lg;
        logic [2:0]  f3;
        logic [31:0] ad, wd, rd;
        @(negedge clk);
        win1 = RR_EN && (last_m == 1'b0);
        g0 = 1'b0;
        g1 = 1'b0;
        if (lock_m && bus.p1_req)            g1 = 1'b1;
        else if (bus.p0_req && bus.p1_req) begin g1 = win1; g0 = !win1; end
        else begin g0 = bus.p0_req; g1 = bus.p1_req; end
        obs_g0 = bus.p0_gnt;
        obs_g1 = bus.p1_gnt;
        chk({tag, ".p0_gnt"}, bus.p0_gnt, 32'(g0));
        chk({tag, ".p1_gnt"}, bus.p1_gnt, 32'(g1));
        wev = 1'b0; f3 = 3'b010; ad = 32'h0; wd = 32'h0;
        if (g0) begin wev = bus.p0_we; f3 = bus.p0_funct3; ad = bus.p0_addr; wd = bus.p0_wdata; end
        if (g1) begin wev = bus.p1_we; f3 = bus.p1_funct3; ad = bus.p1_addr; wd = bus.p1_wdata; end
        lg = ref_legal(wev, f3, ad);
        chk({tag, ".mem_we"}, bus.mem_we, 32'(wev && lg && (g0 || g1)));
        chk({tag, ".mem_store"}, bus.mem_store, 32'(f3));
        chk({tag, ".mem_load"}, bus.mem_load, 32'(f3));
        chk({tag, ".mem_WA"}, bus.mem_WA, ad);
        chk({tag, ".mem_RA"}, bus.mem_RA, ad);
        chk({tag, ".mem_WD"}, bus.mem_WD, wd);
        rd = (lg && !wev) ? ref_load(ad, f3) : 32'h0;
        if ((g0 || g1) && lg && wev) ref_store(ad, f3, wd);
        lock_m = g1 && bus.p1_lock;
        if (g0) last_m = 1'b0;
        else if (g1) last_m = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".p0_rvalid"}, bus.p0_rvalid, 32'(g0));
        chk({tag, ".p0_err"}, bus.p0_err, 32'(g0 && !lg));
        chk({tag, ".p0_rdata"}, bus.p0_rdata, g0 ? rd : 32'h0);
        chk({tag, ".p1_rvalid"}, bus.p1_rvalid, 32'(g1));
        chk({tag, ".p1_err"}, bus.p1_err, 32'(g1 && !lg));
        chk({tag, ".p1_rdata"}, bus.p1_rdata, g1 ? rd : 32'h0);
    endtask

    initial begin
        bit          r0, r1, w0, w1, lk;
        logic [2:0]  f0, f1;
        logic [31:0] a0, a1;
        logic [2:0]  f3_tbl [8];

        rst_n  = 1'b0;
        lock_m = 1'b0;
        last_m = 1'b1;
        set_p0(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        // Requests held during reset must see idle outputs and no response.
        set_p0(1'b1, 1'b1, 3'b010, 32'h4, 32'h12345678);
        set_p1(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b1);
        @(negedge clk);
        chk("rst.p0_gnt", bus.p0_gnt, 32'h0);
        chk("rst.p1_gnt", bus.p1_gnt, 32'h0);
        chk("rst.mem_we", bus.mem_we, 32'h0);
        chk("rst.mem_store", bus.mem_store, 32'h2);
        chk("rst.mem_load", bus.mem_load, 32'h2);
        chk("rst.mem_WA", bus.mem_WA, 32'h0);
        chk("rst.mem_WD", bus.mem_WD, 32'h0);
        @(posedge clk);
        #1;
        chk("rst.p0_rvalid", bus.p0_rvalid, 32'h0);
        chk("rst.p1_rvalid", bus.p1_rvalid, 32'h0);
        chk("rst.p0_rdata", bus.p0_rdata, 32'h0);
        rst_n = 1'b1;
        set_p1(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 64; i++) begin
            set_p0(1'b1, 1'b1, 3'b010, 32'(i * 4), $urandom);
            step("fill");
        end

        set_p0(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        step("sw");
        set_p0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        step("lw");
        chk("req033.rdata", bus.p0_rdata, 32'hDEADBEEF);
        chk("req033.err", bus.p0_err, 32'h0);

        set_p0(1'b1, 1'b1, 3'b001, 32'h13, 32'hCAFEF00D);
        step("sh_misaligned");
        chk("req036.err", bus.p0_err, 32'h1);
        chk("req036.rdata", bus.p0_rdata, 32'h0);
        set_p0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        step("lw_after_sh");
        chk("req036.unchanged", bus.p0_rdata, 32'hDEADBEEF);

        set_p0(1'b1, 1'b1, 3'b000, 32'h8, 32'h00000080);
        step("sb");
        set_p0(1'b1, 1'b0, 3'b100, 32'h8, 32'h0);
        step("lbu");
        chk("req038.lbu", bus.p0_rdata, 32'h00000080);
        set_p0(1'b1, 1'b0, 3'b000, 32'h8, 32'h0);
        step("lb");
        chk("req038.lb", bus.p0_rdata, 32'hFFFFFF80);

        set_p0(1'b0, 1'b0, 3'b010, 32'h40, 32'h0);
        set_p1(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("lock");
            chk("req035.p1_gnt", 32'(obs_g1), 32'h1);
            chk("req035.p0_gnt", 32'(obs_g0), 32'h0);
            set_p0(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        end
        set_p1(1'b0, 1'b0, 3'b000, 32'h21, 32'h0, 1'b0);
        step("unlock");
        chk("req035.p0_after", 32'(obs_g0), 32'h1);

        // Reset lands on the edge that would register a p0 load response.
        set_p0(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("req037.gnt", bus.p0_gnt, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("req037.rvalid", bus.p0_rvalid, 32'h0);
        chk("req037.rdata", bus.p0_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("req037.rvalid2", bus.p0_rvalid, 32'h0);
        rst_n  = 1'b1;
        lock_m = 1'b0;
        last_m = 1'b1;

        for (int i = 0; i < 4; i++) begin
            set_p0(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
            set_p1(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b0);
            step("conflict");
            chk("req034.p0_gnt", 32'(obs_g0), RR_EN ? 32'((i % 2) == 0) : 32'h1);
            chk("req034.p1_gnt", 32'(obs_g1), RR_EN ? 32'((i % 2) == 1) : 32'h0);
        end

        f3_tbl = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
        lk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            w0 = $urandom_range(0, 1);
            w1 = $urandom_range(0, 1);
            f0 = f3_tbl[$urandom_range(0, 7)];
            f1 = f3_tbl[$urandom_range(0, 7)];
            a0 = 32'($urandom_range(0, 255)) & (($urandom_range(0, 3) == 0) ? 32'hFF : 32'hFC);
            a1 = 32'($urandom_range(0, 255)) & (($urandom_range(0, 3) == 0) ? 32'hFF : 32'hFC);
            if ($urandom_range(0, 3) == 0) lk = $urandom_range(0, 1);
            set_p0(r0, w0, f0, a0, $urandom);
            set_p1(r1, w1, f1, a1, $urandom, lk);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
